// File: rtl/mux_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mux_pkg
//  Description : Shared definitions for the mux_arb block: mode encodings
//                and a ceiling-log2 helper used to size channel indices.
//  Contents    : MODE_DIRECT, MODE_RR, clog2()
//  Revision    : 1.0 - initial release
// ============================================================================
package mux_pkg;

    // Values of the 1-bit mode input
    localparam logic MODE_DIRECT = 1'b0;
    localparam logic MODE_RR     = 1'b1;

    // Ceiling log2, minimum result 1 so a 2-channel mux still gets a 1-bit index
    function automatic int clog2(input int n);
        int r;
        r = 1;
        for (int i = 1; i < 31; i++) begin
            if ((1 << i) < n) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage : mux_pkg
`default_nettype wire

// File: rtl/mux_arb_if.sv
`default_nettype none
// ============================================================================
//  Module      : mux_arb_if
//  Description : Handshake/bus bundle between a channel source/sink and the
//                mux_arb block.
//  Ports       : mode, sel, in_valid, in_data, out_ready  (toward mux_arb)
//                in_ready, out_valid, out_data, out_ch, sel_err (from mux_arb)
//  Modports    : master - the environment driving channels and sinking output
//                slave  - the mux_arb block itself
//  Revision    : 1.0 - initial release
// ============================================================================
interface mux_arb_if
    import mux_pkg::*;
#(
    parameter int NUM_CH = 10,
    parameter int WIDTH  = 8
);
    localparam int SEL_W = clog2(NUM_CH);

    logic                      mode;
    logic [SEL_W-1:0]          sel;
    logic [NUM_CH-1:0]         in_valid;
    logic [NUM_CH*WIDTH-1:0]   in_data;
    logic [NUM_CH-1:0]         in_ready;
    logic                      out_valid;
    logic [WIDTH-1:0]          out_data;
    logic [SEL_W-1:0]          out_ch;
    logic                      out_ready;
    logic                      sel_err;

    modport master (
        output mode, sel, in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_ch, sel_err
    );

    modport slave (
        input  mode, sel, in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_ch, sel_err
    );

endinterface : mux_arb_if
`default_nettype wire

// File: rtl/mux_arb_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : rr_arbiter
//  Description : Purely combinational round-robin grant. Searches req starting
//                at ptr and wrapping past NUM_CH-1 to 0; the first requester
//                found wins. The pointer itself lives in the parent.
//  Ports       : req       [NUM_CH] - per-channel request
//                ptr       [SEL_W]  - highest-priority channel (< NUM_CH)
//                grant     [NUM_CH] - one-hot grant, zero if no request
//                grant_idx [SEL_W]  - index of the granted channel
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter
    import mux_pkg::*;
#(
    parameter int NUM_CH = 10,
    parameter int SEL_W  = clog2(NUM_CH)
) (
    input  wire logic [NUM_CH-1:0] req,
    input  wire logic [SEL_W-1:0]  ptr,
    output logic      [NUM_CH-1:0] grant,
    output logic      [SEL_W-1:0]  grant_idx
);

    localparam logic [SEL_W:0] c_num_ch = (SEL_W+1)'(NUM_CH);

    logic [SEL_W:0]   w_sum;
    logic [SEL_W-1:0] w_idx;
    logic             w_found;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        w_found   = 1'b0;
        w_sum     = '0;
        w_idx     = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            // One extra bit so ptr+i cannot overflow before the wrap test
            w_sum = {1'b0, ptr} + (SEL_W+1)'(i);
            if (w_sum >= c_num_ch) begin
                w_sum = w_sum - c_num_ch;
            end
            w_idx = w_sum[SEL_W-1:0];
            if (!w_found && req[w_idx]) begin
                w_found          = 1'b1;
                grant[w_idx]     = 1'b1;
                grant_idx        = w_idx;
            end
        end
    end

endmodule : rr_arbiter
`default_nettype wire

// File: rtl/mux_arb.sv
`default_nettype none
// ============================================================================
//  Module      : mux_arb
//  Description : NUM_CH-to-1 multiplexer with a one-word registered output.
//                Direct mode forwards the channel named by sel; round-robin
//                mode rotates fairly over valid channels. A new word is
//                accepted whenever the output register is empty or is being
//                drained this cycle, giving one word per cycle throughput.
//  Ports       : clk, rst_n (async, active low)
//                bus (mux_arb_if.slave): mode, sel, in_valid, in_data,
//                in_ready, out_valid, out_data, out_ch, out_ready, sel_err
//  Parameters  : NUM_CH (2..16), WIDTH
//  Revision    : 1.0 - initial release
// ============================================================================
module mux_arb
    import mux_pkg::*;
#(
    parameter int NUM_CH = 10,
    parameter int WIDTH  = 8
) (
    input  wire logic clk,
    input  wire logic rst_n,
    mux_arb_if.slave  bus
);

    localparam int                SEL_W     = clog2(NUM_CH);
    localparam logic [SEL_W:0]    c_num_ch  = (SEL_W+1)'(NUM_CH);
    localparam logic [SEL_W-1:0]  c_last_ch = SEL_W'(NUM_CH - 1);

    logic                r_out_valid;
    logic [WIDTH-1:0]    r_out_data;
    logic [SEL_W-1:0]    r_out_ch;
    logic                r_sel_err;
    logic [SEL_W-1:0]    r_ptr;

    logic                w_load;
    logic                w_sel_ok;
    logic [NUM_CH-1:0]   w_dir_grant;
    logic [NUM_CH-1:0]   w_rr_grant;
    logic [SEL_W-1:0]    w_rr_idx;
    logic [NUM_CH-1:0]   w_in_ready;
    logic                w_xfer_in;
    logic [SEL_W-1:0]    w_grant_idx;
    logic [WIDTH-1:0]    w_mux_data;

    // Output register can take a word when empty or when it drains this cycle
    assign w_load   = !r_out_valid || bus.out_ready;
    assign w_sel_ok = ({1'b0, bus.sel} < c_num_ch);

    // Direct-mode grant: decoded compare avoids indexing in_valid out of range
    for (genvar k = 0; k < NUM_CH; k++) begin : g_dir_grant
        assign w_dir_grant[k] = w_sel_ok && (bus.sel == SEL_W'(k)) && bus.in_valid[k];
    end

    rr_arbiter #(
        .NUM_CH (NUM_CH),
        .SEL_W  (SEL_W)
    ) u_rr_arbiter (
        .req       (bus.in_valid),
        .ptr       (r_ptr),
        .grant     (w_rr_grant),
        .grant_idx (w_rr_idx)
    );

    always_comb begin
        w_in_ready = '0;
        if (w_load) begin
            w_in_ready = (bus.mode == MODE_RR) ? w_rr_grant : w_dir_grant;
        end
    end

    assign w_xfer_in   = |w_in_ready;
    assign w_grant_idx = (bus.mode == MODE_RR) ? w_rr_idx : bus.sel;

    // in_ready is one-hot, so an AND-OR mux selects the granted word
    always_comb begin
        w_mux_data = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (w_in_ready[k]) begin
                w_mux_data = w_mux_data | bus.in_data[k*WIDTH +: WIDTH];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_ch    <= '0;
            r_sel_err   <= 1'b0;
            r_ptr       <= '0;
        end else begin
            if (w_xfer_in) begin
                r_out_valid <= 1'b1;
                r_out_data  <= w_mux_data;
                r_out_ch    <= w_grant_idx;
            end else if (bus.out_ready) begin
                // Drain only: data and channel hold their last values
                r_out_valid <= 1'b0;
            end

            // Pointer moves only on a round-robin transfer
            if (w_xfer_in && (bus.mode == MODE_RR)) begin
                r_ptr <= (w_rr_idx == c_last_ch) ? '0 : w_rr_idx + 1'b1;
            end

            // Flagged independent of load so a stalled output still reports it
            r_sel_err <= (bus.mode == MODE_DIRECT) && !w_sel_ok && (|bus.in_valid);
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.out_data  = r_out_data;
    assign bus.out_ch    = r_out_ch;
    assign bus.sel_err   = r_sel_err;

endmodule : mux_arb
`default_nettype wire

// File: tb/tb_mux_arb.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mux_arb
//  Description : Directed self-checking bench for mux_arb (NUM_CH=10,
//                WIDTH=8). Channel k carries 0x10+k unless a test overrides.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mux_arb;

    localparam int NUM_CH = 10;
    localparam int WIDTH  = 8;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_pass;

    mux_arb_if #(.NUM_CH(NUM_CH), .WIDTH(WIDTH)) bus ();

    mux_arb #(
        .NUM_CH (NUM_CH),
        .WIDTH  (WIDTH)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_data();
        for (int k = 0; k < NUM_CH; k++) begin
            bus.in_data[k*WIDTH +: WIDTH] = 8'h10 + 8'(k);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.mode = 1'b0; bus.sel = '0; bus.in_valid = '0; bus.out_ready = 1'b0;
        set_data();
        #12;
        n_checks++; if (bus.out_valid !== 1'b0) $display("FAIL reset_out_valid got=%b exp=0", bus.out_valid); else n_pass++;
        n_checks++; if (bus.out_data !== 8'h00) $display("FAIL reset_out_data got=%h exp=00", bus.out_data); else n_pass++;
        n_checks++; if (bus.out_ch !== 4'd0) $display("FAIL reset_out_ch got=%0d exp=0", bus.out_ch); else n_pass++;
        n_checks++; if (bus.sel_err !== 1'b0) $display("FAIL reset_sel_err got=%b exp=0", bus.sel_err); else n_pass++;
        n_checks++; if (bus.in_ready !== 10'h000) $display("FAIL reset_in_ready got=%h exp=000", bus.in_ready); else n_pass++;
        #2 rst_n = 1'b1;
        tick();
    endtask

    task automatic test_direct();
        bus.mode = 1'b0; bus.sel = 4'd3; bus.in_valid = 10'h008; bus.out_ready = 1'b1;
        bus.in_data[3*WIDTH +: WIDTH] = 8'hA5;
        #1;
        n_checks++; if (bus.in_ready !== 10'h008) $display("FAIL direct_in_ready got=%h exp=008", bus.in_ready); else n_pass++;
        tick();
        n_checks++; if (bus.out_valid !== 1'b1) $display("FAIL direct_out_valid got=%b exp=1", bus.out_valid); else n_pass++;
        n_checks++; if (bus.out_data !== 8'hA5) $display("FAIL direct_out_data got=%h exp=a5", bus.out_data); else n_pass++;
        n_checks++; if (bus.out_ch !== 4'd3) $display("FAIL direct_out_ch got=%0d exp=3", bus.out_ch); else n_pass++;
        bus.in_valid = '0;
        tick();
        n_checks++; if (bus.out_valid !== 1'b0) $display("FAIL drain_out_valid got=%b exp=0", bus.out_valid); else n_pass++;
        n_checks++; if (bus.out_data !== 8'hA5) $display("FAIL drain_hold_data got=%h exp=a5", bus.out_data); else n_pass++;
        set_data();
    endtask

    task automatic test_bad_sel();
        bus.mode = 1'b0; bus.sel = 4'd12; bus.in_valid = 10'h3FF; bus.out_ready = 1'b1;
        #1;
        n_checks++; if (bus.in_ready !== 10'h000) $display("FAIL badsel_in_ready got=%h exp=000", bus.in_ready); else n_pass++;
        tick();
        n_checks++; if (bus.sel_err !== 1'b1) $display("FAIL badsel_err_pulse got=%b exp=1", bus.sel_err); else n_pass++;
        n_checks++; if (bus.out_valid !== 1'b0) $display("FAIL badsel_out_valid got=%b exp=0", bus.out_valid); else n_pass++;
        bus.in_valid = '0;
        tick();
        n_checks++; if (bus.sel_err !== 1'b0) $display("FAIL badsel_err_clear got=%b exp=0", bus.sel_err); else n_pass++;
        bus.sel = 4'd0;
    endtask

    task automatic test_round_robin();
        logic [3:0] exp_ch;
        logic [7:0] exp_d;
        bus.mode = 1'b1; bus.in_valid = 10'h3FF; bus.out_ready = 1'b1;
        for (int i = 0; i < 12; i++) begin
            exp_ch = 4'(i % 10);
            exp_d  = 8'h10 + 8'(i % 10);
            #1;
            n_checks++; if (bus.in_ready !== (10'h001 << exp_ch)) $display("FAIL rr_in_ready[%0d] got=%h exp=%h", i, bus.in_ready, 10'h001 << exp_ch); else n_pass++;
            tick();
            n_checks++; if (bus.out_valid !== 1'b1 || bus.out_ch !== exp_ch || bus.out_data !== exp_d)
                $display("FAIL rr_out[%0d] got v=%b ch=%0d d=%h exp v=1 ch=%0d d=%h", i, bus.out_valid, bus.out_ch, bus.out_data, exp_ch, exp_d);
            else n_pass++;
        end
        bus.in_valid = '0;
        tick();
    endtask

    task automatic test_rr_skip();
        // Pointer is 2 here; a lone request on ch7 moves it to 8
        bus.mode = 1'b1; bus.out_ready = 1'b1; bus.in_valid = 10'h080;
        tick();
        n_checks++; if (bus.out_ch !== 4'd7) $display("FAIL skip_setup_ch got=%0d exp=7", bus.out_ch); else n_pass++;
        bus.in_valid = 10'h005;
        #1;
        n_checks++; if (bus.in_ready !== 10'h001) $display("FAIL skip_wrap_ready got=%h exp=001", bus.in_ready); else n_pass++;
        tick();
        n_checks++; if (bus.out_ch !== 4'd0 || bus.out_data !== 8'h10) $display("FAIL skip_wrap_out got ch=%0d d=%h exp ch=0 d=10", bus.out_ch, bus.out_data); else n_pass++;
        #1;
        n_checks++; if (bus.in_ready !== 10'h004) $display("FAIL skip_next_ready got=%h exp=004", bus.in_ready); else n_pass++;
        tick();
        n_checks++; if (bus.out_ch !== 4'd2 || bus.out_data !== 8'h12) $display("FAIL skip_next_out got ch=%0d d=%h exp ch=2 d=12", bus.out_ch, bus.out_data); else n_pass++;
        bus.in_valid = '0;
        tick();
    endtask

    task automatic test_backpressure();
        // Pointer is 3 here
        bus.mode = 1'b1; bus.in_valid = 10'h3FF; bus.out_ready = 1'b1;
        tick();
        n_checks++; if (bus.out_ch !== 4'd3) $display("FAIL bp_load_ch got=%0d exp=3", bus.out_ch); else n_pass++;
        bus.out_ready = 1'b0;
        for (int c = 0; c < 5; c++) begin
            // One held cycle with an illegal direct select: must flag, not disturb
            if (c == 2) begin
                bus.mode = 1'b0; bus.sel = 4'd12;
            end else begin
                bus.mode = 1'b1; bus.sel = 4'd0;
            end
            #1;
            n_checks++; if (bus.in_ready !== 10'h000) $display("FAIL bp_in_ready[%0d] got=%h exp=000", c, bus.in_ready); else n_pass++;
            tick();
            n_checks++; if (bus.out_valid !== 1'b1 || bus.out_ch !== 4'd3 || bus.out_data !== 8'h13)
                $display("FAIL bp_hold[%0d] got v=%b ch=%0d d=%h exp v=1 ch=3 d=13", c, bus.out_valid, bus.out_ch, bus.out_data);
            else n_pass++;
            n_checks++; if (bus.sel_err !== (c == 2)) $display("FAIL bp_sel_err[%0d] got=%b exp=%b", c, bus.sel_err, (c == 2)); else n_pass++;
        end
        bus.mode = 1'b1; bus.sel = 4'd0; bus.out_ready = 1'b1;
        #1;
        n_checks++; if (bus.in_ready !== 10'h010) $display("FAIL bp_release_ready got=%h exp=010", bus.in_ready); else n_pass++;
        tick();
        n_checks++; if (bus.out_valid !== 1'b1 || bus.out_ch !== 4'd4) $display("FAIL bp_b2b_first got v=%b ch=%0d exp v=1 ch=4", bus.out_valid, bus.out_ch); else n_pass++;
        tick();
        n_checks++; if (bus.out_valid !== 1'b1 || bus.out_ch !== 4'd5 || bus.out_data !== 8'h15)
            $display("FAIL bp_b2b_second got v=%b ch=%0d d=%h exp v=1 ch=5 d=15", bus.out_valid, bus.out_ch, bus.out_data);
        else n_pass++;
    endtask

    task automatic test_async_reset();
        bus.in_valid = '0; bus.out_ready = 1'b0;
        tick();
        n_checks++; if (bus.out_valid !== 1'b1) $display("FAIL ar_pre_valid got=%b exp=1", bus.out_valid); else n_pass++;
        #3 rst_n = 1'b0;
        #1;
        n_checks++; if (bus.out_valid !== 1'b0 || bus.out_ch !== 4'd0 || bus.out_data !== 8'h00)
            $display("FAIL ar_immediate got v=%b ch=%0d d=%h exp v=0 ch=0 d=00", bus.out_valid, bus.out_ch, bus.out_data);
        else n_pass++;
        @(posedge clk);
        #3 rst_n = 1'b1;
        bus.mode = 1'b1; bus.in_valid = 10'h3FF; bus.out_ready = 1'b1;
        #1;
        n_checks++; if (bus.in_ready !== 10'h001) $display("FAIL ar_restart_ready got=%h exp=001", bus.in_ready); else n_pass++;
        tick();
        n_checks++; if (bus.out_valid !== 1'b1 || bus.out_ch !== 4'd0 || bus.out_data !== 8'h10)
            $display("FAIL ar_restart_out got v=%b ch=%0d d=%h exp v=1 ch=0 d=10", bus.out_valid, bus.out_ch, bus.out_data);
        else n_pass++;
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        bus.in_data = '0;
        test_reset();
        test_direct();
        test_bad_sel();
        test_round_robin();
        test_rr_skip();
        test_backpressure();
        test_async_reset();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_mux_arb
`default_nettype wire

// File: doc/mux_arb.md
MUX_ARB -- requirements
Module: mux_arb

Interface
REQ-001 The block SHALL take parameter NUM_CH, default 10, the number of input channels (2..16).
REQ-002 The block SHALL take parameter WIDTH, default 8, the data bits per channel.
REQ-003 The block SHALL take localparam SEL_W, equal to clog2(NUM_CH).
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-006 The block SHALL have port mode, input, 1 bit: 0 = direct select, 1 = round-robin.
REQ-007 The block SHALL have port sel, input, SEL_W bits: channel index used in direct mode.
REQ-008 The block SHALL have port in_valid, input, NUM_CH bits: per-channel valid.
REQ-009 The block SHALL have port in_data, input, NUM_CH*WIDTH bits: channel k occupies bits [k*WIDTH +: WIDTH].
REQ-010 The block SHALL have port in_ready, output, NUM_CH bits: per-channel ready, combinational, one-hot or zero.
REQ-011 The block SHALL have port out_valid, output, 1 bit: the output register holds a word.
REQ-012 The block SHALL have port out_data, output, WIDTH bits: registered selected word.
REQ-013 The block SHALL have port out_ch, output, SEL_W bits: source channel index of out_data.
REQ-014 The block SHALL have port out_ready, input, 1 bit: downstream accepts the word.
REQ-015 The block SHALL have port sel_err, output, 1 bit: registered one-cycle pulse; direct-mode sel >= NUM_CH while in_valid is nonzero.

Function
REQ-016 Transfer conditions SHALL be: input transfer = in_valid[k] & in_ready[k]; output transfer = out_valid & out_ready.
REQ-017 The block SHALL compute load = !out_valid | out_ready; in_ready SHALL be all-zero when load = 0.
REQ-018 In direct mode with load = 1, in_ready[sel] SHALL equal in_valid[sel] when sel < NUM_CH; otherwise all in_ready SHALL be 0.
REQ-019 In round-robin mode with load = 1, the block SHALL grant the first k with in_valid[k] = 1, searching ptr, ptr+1, ..., NUM_CH-1, 0, ..., ptr-1.
REQ-020 After a round-robin transfer from channel g, ptr SHALL become (g+1) mod NUM_CH; wrap from NUM_CH-1 SHALL go to 0.
REQ-021 ptr SHALL be unchanged in cycles without a transfer, in direct mode, and across mode changes.
REQ-022 On an input transfer, out_data, out_ch and out_valid=1 SHALL be registered the next edge; latency 1 cycle.
REQ-023 On an output transfer with no input transfer, out_valid SHALL become 0; out_data and out_ch SHALL hold their values.
REQ-024 A simultaneous input and output transfer SHALL replace the word with no bubble, sustaining 1 word/cycle.
REQ-025 While out_valid=1 and out_ready=0, out_data and out_ch SHALL stay stable and no input SHALL be accepted.
REQ-026 mode and sel SHALL be sampled every cycle; a change SHALL affect only the current cycle's grant and SHALL NOT disturb a held word.
REQ-027 sel_err SHALL pulse for exactly one cycle per offending cycle, including when load = 0.
REQ-028 All-zero in_valid SHALL grant nothing and SHALL leave state unchanged.

Reset
REQ-029 rst_n low SHALL immediately force out_valid=0, out_data=0, out_ch=0, sel_err=0 and ptr=0, regardless of clk.
REQ-030 A reset mid-hold SHALL discard the held word; operation SHALL resume on the first edge after rst_n deasserts.

Structure
REQ-031 Package mux_pkg SHALL hold the MODE_DIRECT/MODE_RR constants and the clog2 function.
REQ-032 Round-robin grant logic SHALL be sub-module rr_arbiter, with inputs req[NUM_CH] and ptr and outputs grant one-hot and grant_idx; it SHALL be purely combinational, with ptr kept in mux_arb.
REQ-033 Target RTL size SHALL be 120-400 lines; no memories and no other clocks.

Verification (NUM_CH=10, WIDTH=8)
REQ-034 Direct test: mode=0, sel=3, in_valid=0x008, ch3 data=0xA5, out_ready=1 -> in_ready=0x008; next cycle out_valid=1, out_data=0xA5, out_ch=3.
REQ-035 Bad select test: mode=0, sel=12, in_valid=0x3FF -> in_ready=0, sel_err pulses 1 cycle later, out_valid remains 0.
REQ-036 Round-robin test: mode=1, all 10 valid, out_ready=1 for 12 cycles -> out_ch=0,1,...,9,0,1 with no bubbles.
REQ-037 Round-robin skip test: mode=1, ptr=8, in_valid=0x005 -> grant ch0, then ptr=1, then ch2 granted next.
REQ-038 Backpressure test: out_valid=1 with out_ready=0 held 5 cycles -> out_data/out_ch stable, in_ready=0; out_ready=1 then gives a back-to-back transfer.
REQ-039 Async reset test: rst_n pulled low between edges while out_valid=1 -> out_valid=0 at once; after release, round-robin restarts at ch0.
